// File: rtl/xor_gate_bf_pkg.sv
// Shared defaults and helpers for the xor_gate_bf registered XOR unit.
package xor_gate_bf_pkg;

  localparam int unsigned XOR_DEF_WIDTH = 1;
  localparam int unsigned XOR_DEF_CNT_W = 16;

  // Increment that sticks at max_v instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    if (v >= max_v) return max_v;
    return v + 32'd1;
  endfunction

endpackage

// File: rtl/xor_gate_bf_cell.sv
// One-bit combinational XOR cell, replicated per operand bit by xor_gate_bf.
module xor_cell (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a ^ b;

endmodule

// File: rtl/xor_gate_bf.sv
// Registered bitwise XOR with valid flag, combinational tap and saturating difference counter.
// Optional parity output enabled by defining XOR_GATE_BF_PARITY_EN.
module xor_gate_bf
  import xor_gate_bf_pkg::*;
#(
  parameter int unsigned WIDTH = XOR_DEF_WIDTH,
  parameter int unsigned CNT_W = XOR_DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y,
  output logic             out_valid,
  output logic [WIDTH-1:0] y_comb,
  output logic [CNT_W-1:0] diff_cnt
`ifdef XOR_GATE_BF_PARITY_EN
  ,
  output logic             parity
`endif
);

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
    xor_cell u_cell (
      .a(a[i]),
      .b(b[i]),
      .y(y_comb[i])
    );
  end

  // Operands are only observed when in_valid is high, so X on idle cycles cannot leak into state.
  always_ff @(posedge clk) begin
    if (rst) begin
      y         <= '0;
      out_valid <= 1'b0;
      diff_cnt  <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        y <= y_comb;
        if (|y_comb) diff_cnt <= CNT_W'(sat_inc(32'(diff_cnt), CNT_MAX));
      end
    end
  end

`ifdef XOR_GATE_BF_PARITY_EN
  assign parity = ^y;
`endif

endmodule

// File: tb/tb_xor_gate_bf.sv
// Self-checking bench for xor_gate_bf: 1-bit default instance and 8-bit instance with a 2-bit counter.
module tb_xor_gate_bf;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  y;
    logic [15:0] dc;
    logic        par;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a1, b1, v1, y1, yc1, ov1;
  logic [15:0] dc1;
  logic [7:0]  a8, b8, y8, yc8;
  logic        v8, ov8;
  logic [1:0]  dc8;
`ifdef XOR_GATE_BF_PARITY_EN
  logic        p1, p8;
`endif

  int pass_cnt = 0;
  int total    = 0;
  logic [7:0] q1[$];
  logic [7:0] q8[$];
  vec_t tab1[4];
  vec_t tab8[6];

  xor_gate_bf u1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(v1),
    .y(y1), .out_valid(ov1), .y_comb(yc1), .diff_cnt(dc1)
`ifdef XOR_GATE_BF_PARITY_EN
    , .parity(p1)
`endif
  );

  xor_gate_bf #(.WIDTH(8), .CNT_W(2)) u8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .in_valid(v8),
    .y(y8), .out_valid(ov8), .y_comb(yc8), .diff_cnt(dc8)
`ifdef XOR_GATE_BF_PARITY_EN
    , .parity(p8)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic a, input logic b, input logic v);
    a1 = a; b1 = b; v1 = v;
    if (v && !rst) q1.push_back(8'(a ^ b));
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic v);
    a8 = a; b8 = b; v8 = v;
    if (v && !rst) q8.push_back(a ^ b);
  endtask

  // Scoreboard: every out_valid pulse must match the oldest pending beat.
  always @(negedge clk) begin
    if (ov1) begin
      check("u1 out_valid has pending beat", 64'(q1.size() != 0), 64'd1);
      if (q1.size() != 0) check("u1 scoreboard y", 64'(y1), 64'(q1.pop_front()));
    end
    if (ov8) begin
      check("u8 out_valid has pending beat", 64'(q8.size() != 0), 64'd1);
      if (q8.size() != 0) check("u8 scoreboard y", 64'(y8), 64'(q8.pop_front()));
    end
  end

  initial begin
    tab1[0] = '{8'h0, 8'h0, 8'h0, 16'd0, 1'b0};
    tab1[1] = '{8'h0, 8'h1, 8'h1, 16'd1, 1'b1};
    tab1[2] = '{8'h1, 8'h0, 8'h1, 16'd2, 1'b1};
    tab1[3] = '{8'h1, 8'h1, 8'h0, 16'd2, 1'b0};
    tab8[0] = '{8'hF0, 8'h3C, 8'hCC, 16'd1, 1'b0};
    tab8[1] = '{8'h01, 8'h00, 8'h01, 16'd2, 1'b1};
    tab8[2] = '{8'hFF, 8'hFF, 8'h00, 16'd2, 1'b0};
    tab8[3] = '{8'hAA, 8'h55, 8'hFF, 16'd3, 1'b0};
    tab8[4] = '{8'h12, 8'h34, 8'h26, 16'd3, 1'b1};
    tab8[5] = '{8'h80, 8'h01, 8'h81, 16'd3, 1'b0};

    // Reset with a live beat on the inputs: the beat must be discarded.
    rst = 1'b1;
    drive1(1'b1, 1'b0, 1'b1);
    drive8(8'h00, 8'h00, 1'b0);
    step(); step();
    check("u1 reset y", 64'(y1), 64'd0);
    check("u1 reset out_valid", 64'(ov1), 64'd0);
    check("u1 reset diff_cnt", 64'(dc1), 64'd0);
    check("u1 y_comb during reset", 64'(yc1), 64'd1);
`ifdef XOR_GATE_BF_PARITY_EN
    check("u1 reset parity", 64'(p1), 64'd0);
`endif
    rst = 1'b0;
    drive1(1'b1, 1'b0, 1'b1);
    step();
    check("u1 first beat y", 64'(y1), 64'd1);
    check("u1 first beat out_valid", 64'(ov1), 64'd1);
    check("u1 first beat diff_cnt", 64'(dc1), 64'd1);

    // Valid gating: equal operands on an idle cycle must not disturb state.
    drive1(1'b1, 1'b1, 1'b0);
    step();
    check("u1 gated y hold", 64'(y1), 64'd1);
    check("u1 gated out_valid low", 64'(ov1), 64'd0);
    check("u1 gated diff_cnt hold", 64'(dc1), 64'd1);
    drive1(1'bx, 1'bx, 1'b0);
    step();
    check("u1 X idle y hold", 64'(y1), 64'd1);
    check("u1 X idle diff_cnt hold", 64'(dc1), 64'd1);

    // Truth table, back to back from a fresh reset.
    rst = 1'b1;
    drive1(1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive1(tab1[i].a[0], tab1[i].b[0], 1'b1);
      #1;
      check($sformatf("u1 y_comb vec%0d", i), 64'(yc1), 64'(tab1[i].y[0]));
      step();
      check($sformatf("u1 y vec%0d", i), 64'(y1), 64'(tab1[i].y[0]));
      check($sformatf("u1 out_valid vec%0d", i), 64'(ov1), 64'd1);
      check($sformatf("u1 diff_cnt vec%0d", i), 64'(dc1), 64'(tab1[i].dc));
`ifdef XOR_GATE_BF_PARITY_EN
      check($sformatf("u1 parity vec%0d", i), 64'(p1), 64'(tab1[i].par));
`endif
    end
    drive1(1'b0, 1'b0, 1'b0);
    step();
    check("u1 final diff_cnt", 64'(dc1), 64'd2);
    check("u1 out_valid drops", 64'(ov1), 64'd0);

    // 8-bit operands with a 2-bit counter: saturation at 3.
    for (int i = 0; i < 6; i++) begin
      drive8(tab8[i].a, tab8[i].b, 1'b1);
      #1;
      check($sformatf("u8 y_comb vec%0d", i), 64'(yc8), 64'(tab8[i].y));
      step();
      check($sformatf("u8 y vec%0d", i), 64'(y8), 64'(tab8[i].y));
      check($sformatf("u8 out_valid vec%0d", i), 64'(ov8), 64'd1);
      check($sformatf("u8 diff_cnt vec%0d", i), 64'(dc8), 64'(tab8[i].dc));
`ifdef XOR_GATE_BF_PARITY_EN
      check($sformatf("u8 parity vec%0d", i), 64'(p8), 64'(tab8[i].par));
`endif
    end

    // Mid-stream reset: beat presented with rst high is dropped and outputs clear next cycle.
    drive8(8'h0F, 8'h00, 1'b1);
    step();
    check("u8 pre-reset y", 64'(y8), 64'h0F);
    rst = 1'b1;
    drive8(8'hFF, 8'h00, 1'b1);
    step();
    check("u8 mid reset y", 64'(y8), 64'd0);
    check("u8 mid reset out_valid", 64'(ov8), 64'd0);
    check("u8 mid reset diff_cnt", 64'(dc8), 64'd0);
`ifdef XOR_GATE_BF_PARITY_EN
    check("u8 mid reset parity", 64'(p8), 64'd0);
`endif
    rst = 1'b0;
    drive8(8'hFF, 8'h00, 1'b0);
    step();
    check("u8 post reset diff_cnt", 64'(dc8), 64'd0);
    check("u8 post reset y", 64'(y8), 64'd0);
    drive8(8'h3C, 8'h0C, 1'b1);
    step();
    check("u8 restart y", 64'(y8), 64'h30);
    check("u8 restart diff_cnt", 64'(dc8), 64'd1);
    drive8(8'h00, 8'h00, 1'b0);
    step(); step();

    check("u1 scoreboard drained", 64'(q1.size()), 64'd0);
    check("u8 scoreboard drained", 64'(q8.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
